// File: rtl/sid_filter_seq.sv
// sid_filter_seq: drives the shared SID filter through a chip 0 then chip 1 pass per sample strobe.
// Define SID_FILTER_SEQ_DUAL_EN to feed the chip 1 pass from its own inputs; otherwise it runs on a zeroed snapshot.
module sid_filter_seq (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               ce_sample,
   input  logic               mode0,
   input  logic               mode1,
   input  logic [15:0]        f0_0,
   input  logic [15:0]        f0_1,
   input  logic [7:0]         res_filt_0,
   input  logic [7:0]         res_filt_1,
   input  logic [7:0]         mode_vol_0,
   input  logic [7:0]         mode_vol_1,
   input  logic signed [21:0] v1_0,
   input  logic signed [21:0] v2_0,
   input  logic signed [21:0] v3_0,
   input  logic signed [21:0] ext_0,
   input  logic signed [21:0] v1_1,
   input  logic signed [21:0] v2_1,
   input  logic signed [21:0] v3_1,
   input  logic signed [21:0] ext_1,
   output logic [2:0]         flt_state,
   output logic               flt_mode,
   output logic [15:0]        flt_f0,
   output logic [7:0]         flt_res_filt,
   output logic [7:0]         flt_mode_vol,
   output logic signed [21:0] flt_voice1,
   output logic signed [21:0] flt_voice2,
   output logic signed [21:0] flt_voice3,
   output logic signed [21:0] flt_ext_in,
   input  logic [17:0]        flt_audio,
   output logic [17:0]        audio_l,
   output logic [17:0]        audio_r,
   output logic               sample_valid,
   output logic               busy,
   output logic               overrun
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t state_q, state_d;
   logic [3:0] cnt_q, cnt_d;

   logic               mode_q, mode_d;
   logic [15:0]        f0_q, f0_d;
   logic [7:0]         res_filt_q, res_filt_d;
   logic [7:0]         mode_vol_q, mode_vol_d;
   logic signed [21:0] voice1_q, voice1_d;
   logic signed [21:0] voice2_q, voice2_d;
   logic signed [21:0] voice3_q, voice3_d;
   logic signed [21:0] ext_q, ext_d;
   logic [17:0]        audio_l_q, audio_l_d;
   logic [17:0]        audio_r_q, audio_r_d;
   logic               sample_valid_q, sample_valid_d;
   logic               overrun_q, overrun_d;

   logic               run, chip1, snap_load, capture;
   logic               src_mode;
   logic [15:0]        src_f0;
   logic [7:0]         src_res_filt, src_mode_vol;
   logic signed [21:0] src_v1, src_v2, src_v3, src_ext;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q        <= IDLE;
         cnt_q          <= 4'd0;
         mode_q         <= 1'b0;
         f0_q           <= 16'd0;
         res_filt_q     <= 8'd0;
         mode_vol_q     <= 8'd0;
         voice1_q       <= 22'sd0;
         voice2_q       <= 22'sd0;
         voice3_q       <= 22'sd0;
         ext_q          <= 22'sd0;
         audio_l_q      <= 18'd0;
         audio_r_q      <= 18'd0;
         sample_valid_q <= 1'b0;
         overrun_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         mode_q         <= mode_d;
         f0_q           <= f0_d;
         res_filt_q     <= res_filt_d;
         mode_vol_q     <= mode_vol_d;
         voice1_q       <= voice1_d;
         voice2_q       <= voice2_d;
         voice3_q       <= voice3_d;
         ext_q          <= ext_d;
         audio_l_q      <= audio_l_d;
         audio_r_q      <= audio_r_d;
         sample_valid_q <= sample_valid_d;
         overrun_q      <= overrun_d;
      end
   end

   // A started pair always runs all 16 steps; strobes during RUN never restart it.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            cnt_d = 4'd0;
            if (ce_sample) state_d = RUN;
         end
         RUN: begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd15) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy      = (state_q == RUN);
      flt_state = busy ? cnt_q[2:0] : 3'd0;
   end

`ifdef SID_FILTER_SEQ_DUAL_EN
   always_comb begin
      src_mode     = chip1 ? mode1      : mode0;
      src_f0       = chip1 ? f0_1       : f0_0;
      src_res_filt = chip1 ? res_filt_1 : res_filt_0;
      src_mode_vol = chip1 ? mode_vol_1 : mode_vol_0;
      src_v1       = chip1 ? v1_1       : v1_0;
      src_v2       = chip1 ? v2_1       : v2_0;
      src_v3       = chip1 ? v3_1       : v3_0;
      src_ext      = chip1 ? ext_1      : ext_0;
   end
`else
   // The chip 1 pass still runs on silence so the filter's rotating chip store stays aligned.
   logic unused_chip1;
   assign unused_chip1 = ^{mode1, f0_1, res_filt_1, mode_vol_1, v1_1, v2_1, v3_1, ext_1};

   always_comb begin
      src_mode     = mode0;
      src_f0       = chip1 ? 16'd0  : f0_0;
      src_res_filt = chip1 ? 8'd0   : res_filt_0;
      src_mode_vol = chip1 ? 8'd0   : mode_vol_0;
      src_v1       = chip1 ? 22'sd0 : v1_0;
      src_v2       = chip1 ? 22'sd0 : v2_0;
      src_v3       = chip1 ? 22'sd0 : v3_0;
      src_ext      = chip1 ? 22'sd0 : ext_0;
   end
`endif

   always_comb begin
      run       = (state_q == RUN);
      chip1     = cnt_q[3];
      snap_load = run && (cnt_q[2:0] == 3'd1);
      capture   = run && (cnt_q[2:0] == 3'd6);

      mode_d     = mode_q;
      f0_d       = f0_q;
      res_filt_d = res_filt_q;
      mode_vol_d = mode_vol_q;
      voice1_d   = voice1_q;
      voice2_d   = voice2_q;
      voice3_d   = voice3_q;
      ext_d      = ext_q;
      audio_l_d  = audio_l_q;
      audio_r_d  = audio_r_q;

      if (snap_load) begin
         mode_d     = src_mode;
         f0_d       = src_f0;
         res_filt_d = src_res_filt;
         mode_vol_d = src_mode_vol;
         voice1_d   = src_v1;
         voice2_d   = src_v2;
         voice3_d   = src_v3;
         ext_d      = src_ext;
      end

      if (capture) begin
`ifdef SID_FILTER_SEQ_DUAL_EN
         if (chip1) audio_r_d = flt_audio;
         else       audio_l_d = flt_audio;
`else
         if (!chip1) begin
            audio_l_d = flt_audio;
            audio_r_d = flt_audio;
         end
`endif
      end

      sample_valid_d = run && (cnt_q == 4'd14);
      overrun_d      = overrun_q | (ce_sample & run);
   end

   assign flt_mode     = mode_q;
   assign flt_f0       = f0_q;
   assign flt_res_filt = res_filt_q;
   assign flt_mode_vol = mode_vol_q;
   assign flt_voice1   = voice1_q;
   assign flt_voice2   = voice2_q;
   assign flt_voice3   = voice3_q;
   assign flt_ext_in   = ext_q;
   assign audio_l      = audio_l_q;
   assign audio_r      = audio_r_q;
   assign sample_valid = sample_valid_q;
   assign overrun      = overrun_q;

endmodule
